stack_based_alu: RTL and testbench

//   Synchronous LIFO stack with an integrated signed ALU. Operands are pushed from

---
 rtl/stack_based_alu.sv | 185 ++++++++++++++++++
 tb/tb_stack_based_alu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_based_alu.sv
// Stack-based signed ALU: an N-bit wide, DEPTH-entry LIFO with ADD/MUL that
// consume the top two entries. One operation per clock, results registered.

// Storage sub-block: entry array plus the occupancy count. The top-level
// decides when a push or pop is legal; this block only performs it.
module stack_based_alu_stack #(
    parameter int N = 16,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop_one,
    input  logic          pop_two,
    input  logic [N-1:0]  push_data,
    output logic [N-1:0]  top_data,
    output logic [N-1:0]  next_data,
    output logic [CW-1:0] count
);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] next_idx;

    // The next free slot is the current count; top and next-below sit just
    // under it. Reads at count<2 return stale data but are never used then.
    assign wr_idx    = AW'(count);
    assign top_idx   = AW'(count - CW'(1));
    assign next_idx  = AW'(count - CW'(2));
    assign top_data  = mem[top_idx];
    assign next_data = mem[next_idx];

    // Entry array has no reset: contents are meaningless once count drops.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Occupancy count; reset empties the stack regardless of array contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push) begin
            count <= count + CW'(1);
        end else if (pop_two) begin
            count <= count - CW'(2);
        end else if (pop_one) begin
            count <= count - CW'(1);
        end
    end

`ifndef SYNTHESIS
    // Debug dump of the live entries, bottom of stack first.
    task print_stack();
        $display("[stack] count=%0d", count);
        for (int i = 0; i < int'(count); i++) begin
            $display("[stack]   entry[%0d] = 0x%h", i, mem[AW'(i)]);
        end
    endtask
`endif

endmodule

// Top level: opcode decode, boundary guards, signed ALU and result registers.
module stack_based_alu #(
    parameter int N = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] input_data,
    input  logic [2:0]   opcode,
    output logic [N-1:0] output_data,
    output logic         overflow
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b100,
        OP_MUL  = 3'b101,
        OP_PUSH = 3'b110,
        OP_POP  = 3'b111
    } opcode_e;

    logic [N-1:0]        top_data;
    logic [N-1:0]        next_data;
    logic [CW-1:0]       count;
    logic                push;
    logic                pop_one;
    logic                pop_two;
    logic                is_full;
    logic                has_one;
    logic                has_two;
    logic [N:0]          sum_wide;
    logic                add_ovf;
    logic signed [2*N-1:0] product;
    logic                mul_ovf;
    logic [N-1:0]        output_next;
    logic                overflow_next;

    stack_based_alu_stack #(
        .N     (N),
        .DEPTH (DEPTH)
    ) stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop_one   (pop_one),
        .pop_two   (pop_two),
        .push_data (input_data),
        .top_data  (top_data),
        .next_data (next_data),
        .count     (count)
    );

    assign is_full = (count == CW'(DEPTH));
    assign has_one = (count != '0);
    assign has_two = (count >= CW'(2));

    // Add one bit wider: overflow is exactly when the two top bits disagree.
    assign sum_wide = {next_data[N-1], next_data} + {top_data[N-1], top_data};
    assign add_ovf  = sum_wide[N] ^ sum_wide[N-1];

    // Full-width signed product; it fits in N bits only when the upper N+1
    // bits are all copies of the result sign.
    assign product = $signed(next_data) * $signed(top_data);
    assign mul_ovf = !((&product[2*N-1:N-1]) || !(|product[2*N-1:N-1]));

    // Decode the opcode into stack moves and next output values; every
    // illegal or reserved case falls back to holding the output.
    always_comb begin
        push          = 1'b0;
        pop_one       = 1'b0;
        pop_two       = 1'b0;
        output_next   = output_data;
        overflow_next = 1'b0;
        case (opcode)
            OP_PUSH: begin
                if (!is_full) begin
                    push = 1'b1;
                end
            end
            OP_POP: begin
                if (has_one) begin
                    pop_one     = 1'b1;
                    output_next = top_data;
                end
            end
            OP_ADD: begin
                if (has_two) begin
                    pop_two       = 1'b1;
                    output_next   = sum_wide[N-1:0];
                    overflow_next = add_ovf;
                end
            end
            OP_MUL: begin
                if (has_two) begin
                    pop_two       = 1'b1;
                    output_next   = product[N-1:0];
                    overflow_next = mul_ovf;
                end
            end
            default: begin
            end
        endcase
    end

    // Result and status registers; overflow lives for one cycle only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            output_data <= '0;
            overflow    <= 1'b0;
        end else begin
            output_data <= output_next;
            overflow    <= overflow_next;
        end
    end

endmodule

// File: tb/tb_stack_based_alu.sv
// Self-checking bench for stack_based_alu: directed scenarios with literal
// expectations, then randomized operations against a queue-based model.
module tb_stack_based_alu;

    localparam int N = 16;
    localparam int DEPTH = 8;
    localparam longint MAX_S = (longint'(1) << (N - 1)) - 1;
    localparam longint MIN_S = -(longint'(1) << (N - 1));

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] input_data = '0;
    logic [2:0]   opcode = OP_NOP;
    logic [N-1:0] output_data;
    logic         overflow;

    int n_vectors = 0;
    int n_miscompares = 0;
    bit check_en = 1'b0;

    logic [N-1:0] model_q[$];
    logic [N-1:0] m_out = '0;
    logic         m_ovf = 1'b0;

    stack_based_alu #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .input_data  (input_data),
        .opcode      (opcode),
        .output_data (output_data),
        .overflow    (overflow)
    );

    always #10 clk = ~clk;

    // Reference model: a queue used as a stack, arithmetic done on wide
    // integers and the range check done directly on the exact result.
    always @(posedge clk or posedge reset) begin : ref_model
        logic signed [N-1:0] a_val;
        logic signed [N-1:0] b_val;
        longint exact;
        if (reset) begin
            model_q.delete();
            m_out <= '0;
            m_ovf <= 1'b0;
        end else begin
            m_ovf <= 1'b0;
            case (opcode)
                OP_PUSH: if (model_q.size() < DEPTH) model_q.push_back(input_data);
                OP_POP:  if (model_q.size() > 0) m_out <= model_q.pop_back();
                OP_ADD, OP_MUL: begin
                    if (model_q.size() >= 2) begin
                        a_val = model_q.pop_back();
                        b_val = model_q.pop_back();
                        if (opcode == OP_ADD) exact = longint'(b_val) + longint'(a_val);
                        else                  exact = longint'(b_val) * longint'(a_val);
                        m_out <= exact[N-1:0];
                        m_ovf <= (exact > MAX_S) || (exact < MIN_S);
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check_value(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Continuous comparison of the DUT against the model, away from the edge.
    always @(negedge clk) begin
        if (check_en) begin
            check_value("cyc_output_data", 32'(output_data), 32'(m_out));
            check_value("cyc_overflow", 32'(overflow), 32'(m_ovf));
            check_value("cyc_count", 32'(dut.stack.count), 32'(model_q.size()));
        end
    end

    // Drive one operation at the falling edge and return just after it executes.
    task automatic apply_stimulus(input logic [2:0] op, input logic [N-1:0] data);
        @(negedge clk);
        opcode = op;
        input_data = data;
        @(posedge clk);
        #2;
    endtask

    // Literal expectations checked against both the DUT and the model.
    task automatic check_output(input string name, input logic [N-1:0] exp_out,
                                input logic exp_ovf, input int exp_count);
        check_value({name, "_out"}, 32'(output_data), 32'(exp_out));
        check_value({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        check_value({name, "_count"}, 32'(dut.stack.count), 32'(exp_count));
        check_value({name, "_model_out"}, 32'(m_out), 32'(exp_out));
        check_value({name, "_model_ovf"}, 32'(m_ovf), 32'(exp_ovf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        opcode = OP_NOP;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [N-1:0] pick_data();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            2: return 16'hFFFF;
            3: return 16'h0001;
            4: return N'($urandom_range(0, 255));
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_en = 1'b1;

        $display("[TB] scenario 1: reset state");
        apply_stimulus(OP_NOP, 16'h0000);
        check_output("s1_nop", 16'h0000, 1'b0, 0);
        dut.stack.print_stack();

        $display("[TB] scenario 2: push/pop");
        apply_stimulus(OP_PUSH, 16'd8);
        apply_stimulus(OP_PUSH, 16'd12);
        apply_stimulus(OP_POP, 16'd0);
        check_output("s2_pop", 16'd12, 1'b0, 1);
        dut.stack.print_stack();

        $display("[TB] scenario 3: short-stack ADD, then MUL");
        apply_stimulus(OP_ADD, 16'd0);
        check_output("s3_add_ignored", 16'd12, 1'b0, 1);
        apply_stimulus(OP_PUSH, 16'd20);
        apply_stimulus(OP_PUSH, 16'd3);
        apply_stimulus(OP_MUL, 16'd0);
        check_output("s3_mul", 16'd60, 1'b0, 1);
        dut.stack.print_stack();

        $display("[TB] scenario 4: ADD to empty, POP on empty");
        apply_stimulus(OP_PUSH, 16'd60);
        apply_stimulus(OP_ADD, 16'd0);
        check_output("s4_add", 16'd68, 1'b0, 0);
        apply_stimulus(OP_POP, 16'd0);
        check_output("s4_pop_empty", 16'd68, 1'b0, 0);
        dut.stack.print_stack();

        $display("[TB] scenario 5: signed add overflow");
        do_reset();
        apply_stimulus(OP_PUSH, 16'hFFFF);
        apply_stimulus(OP_PUSH, 16'h0001);
        apply_stimulus(OP_ADD, 16'd0);
        check_output("s5_add_neg1", 16'h0000, 1'b0, 0);
        apply_stimulus(OP_PUSH, 16'h7FFF);
        apply_stimulus(OP_PUSH, 16'h0001);
        apply_stimulus(OP_ADD, 16'd0);
        check_output("s5_add_ovf", 16'h8000, 1'b1, 0);
        apply_stimulus(OP_NOP, 16'd0);
        check_output("s5_nop_clear", 16'h8000, 1'b0, 0);
        apply_stimulus(3'b010, 16'd0);
        check_output("s5_reserved", 16'h8000, 1'b0, 0);
        dut.stack.print_stack();

        $display("[TB] scenario 6: mul overflow, saturation, async reset");
        apply_stimulus(OP_PUSH, 16'h0100);
        apply_stimulus(OP_PUSH, 16'h0100);
        apply_stimulus(OP_MUL, 16'd0);
        check_output("s6_mul_ovf", 16'h0000, 1'b1, 0);
        for (int i = 1; i <= DEPTH + 1; i++) begin
            apply_stimulus(OP_PUSH, N'(i * 16'h0011));
        end
        check_output("s6_full", 16'h0000, 1'b0, DEPTH);
        dut.stack.print_stack();
        apply_stimulus(OP_POP, 16'd0);
        check_output("s6_top", N'(DEPTH * 16'h0011), 1'b0, DEPTH - 1);
        #3;
        reset = 1'b1;
        #1;
        check_output("s6_async_reset", 16'h0000, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        dut.stack.print_stack();

        $display("[TB] randomized phase");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(OP_PUSH, pick_data());
        end
        for (int i = 0; i < 800; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 40)      apply_stimulus(OP_PUSH, pick_data());
            else if (r < 52) apply_stimulus(OP_POP, pick_data());
            else if (r < 67) apply_stimulus(OP_ADD, pick_data());
            else if (r < 82) apply_stimulus(OP_MUL, pick_data());
            else if (r < 90) apply_stimulus(OP_NOP, pick_data());
            else if (r < 99) apply_stimulus(3'($urandom_range(1, 3)), pick_data());
            else             do_reset();
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
